// File: rtl/seven_seg_dec.sv
// seven_seg_dec: recovers per-digit hex value, decimal point and validity from a scanned active-low 7-segment bus.
// Optional alternate glyphs (27->7, 67->9) are accepted when SEG_DEC_ALT_GLYPH_EN is defined.
module seven_seg_dec #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [7:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   valid,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic                    upd,
   output logic                    err
);
   localparam int SW = NUM_DIGITS + 8;
   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   state_t                state, state_nx;
   logic [SW-1:0]         smp;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  changed, commit, onehot, legal, blank, ok;
   logic [NUM_DIGITS-1:0] anodes;
   logic [4:0]            g;
   logic                  sdp;

   // {legal, value}; anything unlisted decodes as illegal
   function automatic logic [4:0] glyph(input logic [6:0] s);
      case (s)
         7'h3F: glyph = 5'h10;
         7'h06: glyph = 5'h11;
         7'h5B: glyph = 5'h12;
         7'h4F: glyph = 5'h13;
         7'h66: glyph = 5'h14;
         7'h6D: glyph = 5'h15;
         7'h7D: glyph = 5'h16;
         7'h07: glyph = 5'h17;
         7'h7F: glyph = 5'h18;
         7'h6F: glyph = 5'h19;
         7'h77: glyph = 5'h1A;
         7'h7C: glyph = 5'h1B;
         7'h39: glyph = 5'h1C;
         7'h5E: glyph = 5'h1D;
         7'h79: glyph = 5'h1E;
         7'h71: glyph = 5'h1F;
`ifdef SEG_DEC_ALT_GLYPH_EN
         7'h27: glyph = 5'h17;
         7'h67: glyph = 5'h19;
`else
         7'h27, 7'h67: glyph = 5'h00;
`endif
         default: glyph = 5'h00;
      endcase
   endfunction

   assign changed = {an_n, seg_n} != smp;
   assign anodes  = ~smp[SW-1:8];
   assign sdp     = ~smp[7];
   assign g       = glyph(~smp[6:0]);
   assign legal   = g[4];
   assign blank   = smp[6:0] == 7'h7F;
   assign onehot  = (anodes != '0) && ((anodes & (anodes - 1'b1)) == '0);
   assign ok      = onehot && (legal || blank);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      if (changed) begin
         state_nx = SETTLE;
         cnt_nx   = '0;
      end else if (state == SETTLE) begin
         if (cnt == CW'(STABLE_CYCLES - 1)) begin
            commit   = 1'b1;
            state_nx = HELD;
         end else
            cnt_nx = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         smp    <= '1;
         digits <= '0;
         valid  <= '0;
         dp     <= '0;
         upd    <= 1'b0;
         err    <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         smp   <= {an_n, seg_n};
         upd   <= commit && ok;
         err   <= commit && (anodes != '0) && !ok;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && onehot && anodes[i]) begin
               if (legal)
                  digits[4*i +: 4] <= g[3:0];
               valid[i] <= legal;
               if (legal || blank)
                  dp[i] <= sdp;
            end
         end
      end
   end
endmodule

// File: tb/tb_seven_seg_dec.sv
// tb_seven_seg_dec: directed and random checks of seven_seg_dec against a run-length reference model.
module tb_seven_seg_dec;
   localparam int ND = 4;
   localparam int SC = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    seg_n;
   logic [ND-1:0] an_n;
   logic [4*ND-1:0] digits;
   logic [ND-1:0] valid, dp;
   logic          upd, err;

   seven_seg_dec #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .seg_n(seg_n), .an_n(an_n),
      .digits(digits), .valid(valid), .dp(dp), .upd(upd), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int dut_upd_cnt, dut_err_cnt;

   logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [4*ND-1:0] exp_dig;
   logic [ND-1:0]   exp_val, exp_dp;
   logic            exp_upd, exp_err;
   logic [ND+7:0]   m_prev;
   int              m_run;
   bit              m_armed;

   function automatic int lookup(input logic [6:0] s);
      for (int v = 0; v < 16; v++)
         if (tbl[v] == s) return v;
`ifdef SEG_DEC_ALT_GLYPH_EN
      if (s == 7'h27) return 7;
      if (s == 7'h67) return 9;
`endif
      return -1;
   endfunction

   task automatic m_reset();
      exp_dig = '0; exp_val = '0; exp_dp = '0; exp_upd = 0; exp_err = 0;
      m_prev = '1; m_run = 0; m_armed = 0;
   endtask

   // A value present for SC+1 consecutive edges (counting the edge it first appears at) commits once.
   task automatic model(input logic [ND-1:0] a, input logic [7:0] s);
      logic [ND-1:0] act;
      logic [6:0] gl;
      int v;
      exp_upd = 0; exp_err = 0;
      if ({a, s} != m_prev) begin
         m_prev = {a, s}; m_run = 1; m_armed = 1;
      end else if (m_armed)
         m_run++;
      if (m_armed && m_run == SC + 1) begin
         m_armed = 0;
         act = ~a; gl = ~s[6:0]; v = lookup(gl);
         if ($countones(act) == 1) begin
            for (int i = 0; i < ND; i++) if (act[i]) begin
               if (v >= 0) begin
                  exp_dig[4*i +: 4] = 4'(v); exp_val[i] = 1; exp_dp[i] = ~s[7]; exp_upd = 1;
               end else if (gl == 0) begin
                  exp_val[i] = 0; exp_dp[i] = ~s[7]; exp_upd = 1;
               end else begin
                  exp_val[i] = 0; exp_err = 1;
               end
            end
         end else if ($countones(act) > 1)
            exp_err = 1;
      end
   endtask

   task automatic drive(input logic [ND-1:0] a, input logic [7:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         an_n = a; seg_n = s;
         @(posedge clk);
         model(a, s);
         #1;
         if (upd === 1'b1) dut_upd_cnt++;
         if (err === 1'b1) dut_err_cnt++;
      end
   endtask

   task automatic clr_cnt();
      dut_upd_cnt = 0; dut_err_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1; an_n = '1; seg_n = '1; m_reset(); clr_cnt();
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (digits !== '0) begin n_fail++; $display("FAIL reset_digits: got %h expected 0", digits); end
      n_chk++; if (valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
      n_chk++; if (dp !== '0) begin n_fail++; $display("FAIL reset_dp: got %b expected 0", dp); end
      n_chk++; if ({upd, err} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b expected 00", {upd, err}); end
      rst = 0;
      drive('1, 8'hFF, 6);
      n_chk++; if (dut_upd_cnt + dut_err_cnt !== 0) begin n_fail++; $display("FAIL idle_all_ones: got %0d pulses expected 0", dut_upd_cnt + dut_err_cnt); end
   endtask

   task automatic test_basic();
      clr_cnt();
      drive(4'b1110, ~8'h5B, 3);
      n_chk++; if (valid[0] !== 1'b0 || dut_upd_cnt !== 0) begin n_fail++; $display("FAIL basic_early: got valid0=%b upd_cnt=%0d expected 0/0", valid[0], dut_upd_cnt); end
      drive(4'b1110, ~8'h5B, 1);
      n_chk++; if (digits[3:0] !== 4'h2) begin n_fail++; $display("FAIL basic_digit: got %h expected 2", digits[3:0]); end
      n_chk++; if ({valid[0], dp[0], upd} !== 3'b101) begin n_fail++; $display("FAIL basic_flags: got %b expected 101", {valid[0], dp[0], upd}); end
      drive(4'b1110, ~8'h5B, 5);
      n_chk++; if (dut_upd_cnt !== 1) begin n_fail++; $display("FAIL basic_single_upd: got %0d expected 1", dut_upd_cnt); end
   endtask

   task automatic test_scan();
      clr_cnt();
      drive(4'b1110, ~8'h06, 6);
      drive(4'b1101, ~8'h77, 6);
      drive(4'b1011, ~8'hF1, 6);
      drive(4'b0111, ~8'h7F, 6);
      n_chk++; if (digits !== 16'h8FA1) begin n_fail++; $display("FAIL scan_digits: got %h expected 8fa1", digits); end
      n_chk++; if (valid !== 4'hF) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", valid); end
      n_chk++; if (dp !== 4'b0100) begin n_fail++; $display("FAIL scan_dp: got %b expected 0100", dp); end
      n_chk++; if (dut_err_cnt !== 0 || dut_upd_cnt !== 4) begin n_fail++; $display("FAIL scan_pulses: got err=%0d upd=%0d expected 0/4", dut_err_cnt, dut_upd_cnt); end
   endtask

   task automatic test_restart();
      clr_cnt();
      drive(4'b1110, ~8'h5B, 2);
      drive(4'b1110, ~8'h4F, 3);
      n_chk++; if (digits[3:0] !== 4'h1 || dut_upd_cnt !== 0) begin n_fail++; $display("FAIL restart_nocommit: got %h upd=%0d expected 1/0", digits[3:0], dut_upd_cnt); end
      drive(4'b1110, ~8'h4F, 1);
      n_chk++; if (digits[3:0] !== 4'h3 || upd !== 1'b1) begin n_fail++; $display("FAIL restart_commit: got %h upd=%b expected 3/1", digits[3:0], upd); end
   endtask

   task automatic test_illegal();
      drive(4'b1110, ~8'h6D, 5);
      clr_cnt();
      drive(4'b1110, ~8'h49, 5);
      n_chk++; if (dut_err_cnt !== 1 || dut_upd_cnt !== 0) begin n_fail++; $display("FAIL illegal_pulses: got err=%0d upd=%0d expected 1/0", dut_err_cnt, dut_upd_cnt); end
      n_chk++; if (valid[0] !== 1'b0 || digits[3:0] !== 4'h5) begin n_fail++; $display("FAIL illegal_state: got valid0=%b digit=%h expected 0/5", valid[0], digits[3:0]); end
      drive(4'b1100, ~8'h06, 5);
      n_chk++; if (dut_err_cnt !== 2 || digits !== exp_dig || valid !== exp_val) begin n_fail++; $display("FAIL multi_anode: got err=%0d digits=%h valid=%b expected 2/%h/%b", dut_err_cnt, digits, valid, exp_dig, exp_val); end
   endtask

   task automatic test_alt_glyph();
      clr_cnt();
      drive(4'b1101, ~8'h27, 5);
`ifdef SEG_DEC_ALT_GLYPH_EN
      n_chk++; if (digits[7:4] !== 4'h7 || valid[1] !== 1'b1 || dut_err_cnt !== 0) begin n_fail++; $display("FAIL alt_glyph: got %h valid1=%b err=%0d expected 7/1/0", digits[7:4], valid[1], dut_err_cnt); end
`else
      n_chk++; if (valid[1] !== 1'b0 || dut_err_cnt !== 1) begin n_fail++; $display("FAIL alt_glyph: got valid1=%b err=%0d expected 0/1", valid[1], dut_err_cnt); end
`endif
   endtask

   task automatic test_blank();
      clr_cnt();
      drive(4'b0111, 8'h7F, 5);
      n_chk++; if ({valid[3], dp[3]} !== 2'b01 || digits[15:12] !== 4'h8) begin n_fail++; $display("FAIL blank_state: got v=%b dp=%b d=%h expected 0/1/8", valid[3], dp[3], digits[15:12]); end
      n_chk++; if (dut_upd_cnt !== 1 || dut_err_cnt !== 0) begin n_fail++; $display("FAIL blank_pulses: got upd=%0d err=%0d expected 1/0", dut_upd_cnt, dut_err_cnt); end
   endtask

   task automatic test_reset_mid();
      clr_cnt();
      drive(4'b1110, ~8'h06, 3);
      rst = 1;
      #1;
      n_chk++; if ({digits, valid, dp, upd, err} !== '0) begin n_fail++; $display("FAIL midreset_async: got d=%h v=%b dp=%b u=%b e=%b expected all 0", digits, valid, dp, upd, err); end
      @(posedge clk); #1;
      n_chk++; if (upd !== 1'b0 || dut_upd_cnt !== 0) begin n_fail++; $display("FAIL midreset_no_upd: got upd=%b cnt=%0d expected 0/0", upd, dut_upd_cnt); end
      m_reset();
      rst = 0;
      drive(4'b1110, ~8'h06, SC);
      n_chk++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL midreset_early: got valid0=%b expected 0", valid[0]); end
      drive(4'b1110, ~8'h06, 1);
      n_chk++; if (digits[3:0] !== 4'h1 || valid[0] !== 1'b1 || upd !== 1'b1) begin n_fail++; $display("FAIL midreset_commit: got %h v=%b u=%b expected 1/1/1", digits[3:0], valid[0], upd); end
   endtask

   task automatic test_random();
      logic [ND-1:0] a;
      logic [7:0] s;
      int hold;
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5, 6: a = ~(ND'(1) << $urandom_range(0, ND - 1));
            7: a = '1;
            default: a = ND'($urandom);
         endcase
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: s = {1'($urandom), ~tbl[$urandom_range(0, 15)]};
            6: s = {1'($urandom), 7'h7F};
            7: s = {1'($urandom), ($urandom_range(0, 1) != 0) ? ~7'h27 : ~7'h67};
            default: s = 8'($urandom);
         endcase
         hold = $urandom_range(1, 6);
         for (int k = 0; k < hold; k++) begin
            drive(a, s, 1);
            n_chk++; if (digits !== exp_dig) begin n_fail++; $display("FAIL rnd_digits: got %h expected %h", digits, exp_dig); end
            n_chk++; if (valid !== exp_val) begin n_fail++; $display("FAIL rnd_valid: got %b expected %b", valid, exp_val); end
            n_chk++; if (dp !== exp_dp) begin n_fail++; $display("FAIL rnd_dp: got %b expected %b", dp, exp_dp); end
            n_chk++; if ({upd, err} !== {exp_upd, exp_err}) begin n_fail++; $display("FAIL rnd_pulses: got %b expected %b", {upd, err}, {exp_upd, exp_err}); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_scan();
      test_restart();
      test_illegal();
      test_alt_glyph();
      test_blank();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seven_seg_dec.md
# seven_seg_dec

Scanning seven-segment decoder: the inverse of the display encoder. It watches a multiplexed, active-low segment/anode bus driven by the display path and recovers, per digit, the hex value, the decimal point and a validity flag. Each sample is committed only after the bus has been stable for a set number of cycles. It sits beside the display driver as an in-system monitor and gives the test bench a self-checking readback of what the Genius board actually shows.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (1..8)
- STABLE_CYCLES, 3, consecutive unchanged cycles required before commit (>=1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- seg_n  in  8  segments, active low; bit0=a … bit6=g, bit7=dp
- an_n  in  NUM_DIGITS  digit anode select, active low, one-hot-low when valid
- digits  out  4*NUM_DIGITS  decoded values; digit i at [4i+3:4i]
- valid  out  NUM_DIGITS  digit i holds a legal, non-blank glyph
- dp  out  NUM_DIGITS  decimal point of digit i (1 = lit)
- upd  out  1  one-cycle pulse on each successful commit
- err  out  1  one-cycle pulse on an illegal glyph or multiple active anodes

## Operation
- Sample register `smp` captures {an_n, seg_n} every cycle. `cnt` is a stability counter.
- FSM states:
  - IDLE: after reset.
  - SETTLE: counting stable cycles.
  - HELD: committed; wait for the next change.
- Any cycle where the inputs differ from `smp`: cnt←0, state←SETTLE, from any state.
- In SETTLE with the inputs equal to `smp`:
  - if cnt==STABLE_CYCLES-1: commit, state←HELD;
  - else cnt←cnt+1.
- IDLE and HELD do nothing while the inputs are unchanged. There is never more than one commit per stable interval.
- Commit, with seg = ~smp[6:0] and anodes = ~an_n from `smp`:
  - Exactly one anode i active:
    - seg in the legal table: digits[i]←value, valid[i]←1, dp[i]←~seg_n[7], upd←1.
    - seg==0x00 (blank): valid[i]←0, dp[i]←~seg_n[7], digits[i] unchanged, upd←1, no err.
    - otherwise: valid[i]←0, digits[i] and dp[i] unchanged, err←1.
  - No anode active: no action, no pulse.
  - Two or more anodes active: no digit change, err←1.
- Legal table (active-high seg → value):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F
- Digits not addressed by a commit keep their state indefinitely.

## Timing
- Reset values: `smp` = all ones; state IDLE; cnt=0; digits=0, valid=0, dp=0, upd=0, err=0. All outputs are registered.
- Latency: the inputs change before edge E0 and then stay constant. The commit takes effect at edge E(STABLE_CYCLES). Outputs are valid after STABLE_CYCLES+1 rising edges. For the default this is 4 edges.
- upd and err are high for exactly the one cycle after the commit edge and are never high together.
- A change at or before the commit edge restarts the count; that edge does not commit.
- Asserting rst in any state, including SETTLE one cycle before commit, returns everything to reset values immediately. No pulse is emitted.
- Equal inputs to the reset `smp` value (all ones) after reset cause no commit until the inputs change.

## Configuration
- SEG_DEC_ALT_GLYPH_EN:
  - Defined: also accept the alternate glyphs 27→7 (7 with segment f) and 67→9 (9 without segment d). Both commit as legal.
  - Undefined: 27 and 67 are illegal: valid[i]←0 and err pulses.

## Test plan
- Reset, then hold an_n=1110 and seg_n=~0x5B for 4 cycles -> after the 4th edge: digits[3:0]=2, valid[0]=1, dp[0]=0, upd pulses once. Holding longer produces no further upd.
- Scan 4 digits with an_n=1110/1101/1011/0111 and glyphs 1/A/F/8 with dp on digit 2, 6 cycles each -> digits=0x8FA1, valid=1111, dp=0100. err stays 0.
- Hold seg_n=~0x5B for 2 cycles, then switch to ~0x4F and hold 4 cycles -> no commit of 2. Digit 0 becomes 3 at edge 4 after the switch.
- Commit digit 0 as 5, then drive seg 0x49 (illegal) stable -> err pulse, valid[0]=0, digits[3:0] still 5. Then drive an_n=1100 -> err pulse, no digit changes.
- Drive seg 0x27 on digit 1 -> with SEG_DEC_ALT_GLYPH_EN: digits[7:4]=7, valid[1]=1. Without it: err, valid[1]=0.
- Assert rst during SETTLE one cycle before the commit edge -> all outputs 0, no upd. After release, a stable bus commits after a full STABLE_CYCLES+1 edges.
